// File: rtl/fetch_const_collector_pkg.sv
// Shared types and helpers for the instruction constant collector.
package fetch_const_collector_pkg;

  localparam int CONST_W_DEF = 64;
  localparam int MQ_N_DEF    = 4;
  localparam int CNT_W_DEF   = 4;

  typedef logic [1:0] const_code_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DISP = 2'd1,
    ST_IMM  = 2'd2,
    ST_DONE = 2'd3
  } cstate_t;

  // Code 3 means 8 bytes for an immediate but is a reserved 4-byte form for a displacement.
  function automatic logic [3:0] code_to_bytes(input const_code_t code, input logic is_imm);
    logic [3:0] n;
    case (code)
      2'd0:    n = 4'd1;
      2'd1:    n = 4'd2;
      2'd2:    n = 4'd4;
      default: n = is_imm ? 4'd8 : 4'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/fetch_const_collector_assembler.sv
// One constant field: little-endian byte insert, byte counter and sign/zero extension
// applied on the cycle the last byte is captured.
module const_byte_assembler
  import fetch_const_collector_pkg::*;
#(
  parameter int CONST_W = CONST_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_clear,
  input  logic               i_byte_we,
  input  logic               i_sext,
  input  logic [CNT_W-1:0]   i_size,
  input  logic [7:0]         i_byte,
  output logic               o_last,
  output logic [CONST_W-1:0] o_value
);

  localparam int NB = CONST_W / 8;

  logic [CNT_W-1:0]   r_cnt;
  logic [CONST_W-1:0] r_acc;
  logic [CONST_W-1:0] w_acc_next;
  logic               w_fill;

  assign o_last  = i_byte_we && (r_cnt == i_size - CNT_W'(1));
  assign w_fill  = i_sext & i_byte[7];
  assign o_value = r_acc;

  always_comb begin
    w_acc_next = r_acc;
    for (int k = 0; k < NB; k++) begin
      if (k == int'(r_cnt)) begin
        w_acc_next[8*k +: 8] = i_byte;
      end else if (o_last && (k > int'(r_cnt))) begin
        w_acc_next[8*k +: 8] = {8{w_fill}};
      end else begin
        w_acc_next[8*k +: 8] = r_acc[8*k +: 8];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else if (i_byte_we) begin
      r_cnt <= r_cnt + CNT_W'(1);
      r_acc <= w_acc_next;
    end
  end

endmodule

// File: rtl/fetch_const_collector.sv
// Collects the displacement then immediate of one instruction, one byte per cycle,
// and holds the result on a valid/ready output until accepted.
module fetch_const_collector
  import fetch_const_collector_pkg::*;
#(
  parameter int MQ_N    = MQ_N_DEF,
  parameter int CONST_W = CONST_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_flush,
  input  logic               i_start_valid,
  output logic               o_start_ready,
  input  logic               i_disp_en,
  input  logic [1:0]         i_disp_code,
  input  logic               i_imm_en,
  input  logic [1:0]         i_imm_code,
  input  logic               i_imm_sext,
  input  logic [MQ_N-1:0]    i_start_to,
  input  logic               i_byte_valid,
  input  logic [7:0]         i_byte_data,
  output logic               o_byte_ready,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [CONST_W-1:0] o_out_disp,
  output logic [CONST_W-1:0] o_out_imm,
  output logic [MQ_N-1:0]    o_out_to,
  output logic [CNT_W-1:0]   o_out_len
);

  cstate_t          r_state;
  cstate_t          w_state_next;
  logic             r_imm_en;
  logic             r_imm_sext;
  logic [CNT_W-1:0] r_disp_size;
  logic [CNT_W-1:0] r_imm_size;
  logic [CNT_W-1:0] r_len;
  logic [MQ_N-1:0]  r_to;
  logic             w_start;
  logic             w_byte_xfer;
  logic             w_disp_we;
  logic             w_imm_we;
  logic             w_disp_last;
  logic             w_imm_last;
  logic             w_clear;

  // Flush masks every handshake, so a byte or start seen with it is never taken.
  assign w_start     = i_start_valid && !i_flush && (r_state == ST_IDLE);
  assign w_byte_xfer = i_byte_valid && !i_flush && ((r_state == ST_DISP) || (r_state == ST_IMM));
  assign w_disp_we   = w_byte_xfer && (r_state == ST_DISP);
  assign w_imm_we    = w_byte_xfer && (r_state == ST_IMM);
  assign w_clear     = w_start || i_flush;

  always_comb begin
    w_state_next  = r_state;
    o_start_ready = 1'b0;
    o_byte_ready  = 1'b0;
    o_out_valid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_start_ready = 1'b1;
        if (i_start_valid) begin
          w_state_next = i_disp_en ? ST_DISP : (i_imm_en ? ST_IMM : ST_DONE);
        end
      end
      ST_DISP: begin
        o_byte_ready = 1'b1;
        if (w_disp_last) begin
          w_state_next = r_imm_en ? ST_IMM : ST_DONE;
        end
      end
      ST_IMM: begin
        o_byte_ready = 1'b1;
        if (w_imm_last) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        o_out_valid = 1'b1;
        if (i_out_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
    if (i_flush) begin
      w_state_next  = ST_IDLE;
      o_start_ready = 1'b0;
      o_byte_ready  = 1'b0;
      o_out_valid   = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_imm_en    <= 1'b0;
      r_imm_sext  <= 1'b0;
      r_disp_size <= '0;
      r_imm_size  <= '0;
      r_to        <= '0;
    end else if (w_start) begin
      r_imm_en    <= i_imm_en;
      r_imm_sext  <= i_imm_sext;
      r_disp_size <= CNT_W'(code_to_bytes(i_disp_code, 1'b0));
      r_imm_size  <= CNT_W'(code_to_bytes(i_imm_code, 1'b1));
      r_to        <= i_start_to;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || w_clear) begin
      r_len <= '0;
    end else if (w_byte_xfer) begin
      r_len <= r_len + CNT_W'(1);
    end
  end

  const_byte_assembler #(.CONST_W(CONST_W), .CNT_W(CNT_W)) u_disp (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (w_clear),
    .i_byte_we (w_disp_we),
    .i_sext    (1'b1),
    .i_size    (r_disp_size),
    .i_byte    (i_byte_data),
    .o_last    (w_disp_last),
    .o_value   (o_out_disp)
  );

  const_byte_assembler #(.CONST_W(CONST_W), .CNT_W(CNT_W)) u_imm (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (w_clear),
    .i_byte_we (w_imm_we),
    .i_sext    (r_imm_sext),
    .i_size    (r_imm_size),
    .i_byte    (i_byte_data),
    .o_last    (w_imm_last),
    .o_value   (o_out_imm)
  );

  assign o_out_to  = r_to;
  assign o_out_len = r_len;

endmodule
